branch_predictor_gshare: RTL
============================

Name: branch_predictor_gshare

Overview:
Parametrised next-generation fetch predictor: a direct-mapped BTB, a gshare pattern history table (PHT) indexed by PC XOR global history, and a return address stack (RAS). The IF stage reads predictions combinationally. The EX stage trains the tables and repairs speculative global history on a mispredict. It drops into the core's IF/EX pipeline; each fetched instruction carries a GHR snapshot down the pipe for training and recovery.

Parameters:
BTB_ENTRIES, 64, BTB entries (power of 2); BTB_IDX = log2(BTB_ENTRIES)
PHT_ENTRIES, 256, 2-bit counters (power of 2); PHT_IDX = log2(PHT_ENTRIES)
GHR_BITS, 8, global history length (<= PHT_IDX)
TAG_BITS, 20, BTB tag bits, taken from pc[BTB_IDX+2+TAG_BITS-1 : BTB_IDX+2]
RAS_DEPTH, 8, return stack entries (power of 2, >= 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
pc_if  in  32  fetch PC
if_valid  in  1  fetch accepted this cycle; commits speculative GHR/RAS side effects
predict_taken  out  1  redirect fetch
predict_target  out  32  redirect address
predict_ghr  out  GHR_BITS  GHR snapshot before this fetch's update; travels with instruction
ex_valid  in  1  EX holds a valid control-flow instruction
pc_ex  in  32  PC of EX instruction
is_branch_ex, is_jump_ex, is_call_ex, is_ret_ex  in  1 each  instruction class; at most one set
branch_taken_ex  in  1  actual outcome (jumps/calls/rets report 1)
branch_target_ex  in  32  actual target
ghr_ex  in  GHR_BITS  snapshot carried from IF
mispredict_ex  in  1  EX redirect (direction or target wrong)

Behaviour:
- Reset (async, active-high): all BTB valid=0; PHT=2'b01; GHR=0; RAS ptr=0, count=0. Outputs derive from state, so predict_taken=0 during and after reset until the BTB is trained. BTB tag/target/type storage is not reset.
- BTB entry fields: valid, tag, target[31:0], type {COND=0, JUMP=1, CALL=2, RET=3}. bidx = pc[BTB_IDX+1:2].
- Prediction (combinational, zero latency); hit = valid && tag match.
  - hit COND: pidx = pc_if[PHT_IDX+1:2] XOR zero-extended GHR; taken = PHT[pidx] >= 2; target = BTB target.
  - hit JUMP or CALL: taken=1, target=BTB target.
  - hit RET: taken=1; target = RAS top if count>0, else BTB target.
  - miss: taken=0, target=pc_if+4.
- Speculative update, only on if_valid && !mispredict_ex:
  - hit COND: GHR <= {GHR[GHR_BITS-2:0], predict_taken}.
  - hit CALL: push pc_if+4; ptr <= ptr+1 (mod RAS_DEPTH); count saturates at RAS_DEPTH. Push when full overwrites the oldest entry.
  - hit RET: pop if count>0 (ptr-1, count-1); pop when empty is a no-op.
- Training (ex_valid):
  - is_branch_ex: PHT[pc_ex[PHT_IDX+1:2] XOR ghr_ex] saturates +1 if taken, -1 if not taken (range 0..3).
  - Any class with branch_taken_ex=1: BTB[bidx_ex] <= {1, tag_ex, branch_target_ex, type}. Not-taken COND writes nothing to the BTB.
- Recovery (mispredict_ex): GHR <= {ghr_ex[GHR_BITS-2:0], branch_taken_ex} for branches, ghr_ex otherwise. Same-cycle IF side effects are discarded (wrong path). RAS is not repaired; this is a known accuracy limitation, not an error.
- Same cycle, same index for read and write: the IF prediction sees pre-write contents (no bypass). The write takes effect next cycle.
- mispredict_ex without ex_valid is ignored.

Test Plan:
- Reset: assert rst mid-run after training → predict_taken=0 for any pc_if; GHR=0, predict_ghr=0.
- COND training: branch at 0x100, taken 2×, ghr_ex=0, target 0x80 → next fetch of 0x100 with GHR=0 gives predict_taken=1, target 0x80. Two not-taken updates → predict_taken=0.
- GHR: three predicted-taken COND hits with if_valid → predict_ghr=0b111. Then mispredict_ex with ghr_ex=0x05, not-taken branch → GHR=0x0A. A simultaneous if_valid hit is ignored.
- CALL/RET: train CALL at 0x200 and RET at 0x300 → fetch 0x200 pushes 0x204; fetch 0x300 predicts 0x204; a second fetch of 0x300 (RAS empty) predicts the BTB target.
- RAS overflow: RAS_DEPTH+1 nested calls with returns 0x1004,0x2004,… → first RAS_DEPTH returns pop newest-first; the oldest was overwritten, so return RAS_DEPTH+1 falls back to the BTB target.
- Aliasing/bypass: pc_if and pc_ex at the same BTB index, same cycle, different tags → the prediction uses the old entry; the next cycle shows the new tag (old PC misses).

Source files
------------

// File: rtl/branch_predictor_gshare_if.sv
// Fetch/execute port bundle of the gshare branch predictor.
// The core drives through master; the predictor answers through slave.
interface branch_predictor_gshare_if #(
  parameter int GHR_BITS = 8
);
  logic [31:0]         pc_if;
  logic                if_valid;
  logic                predict_taken;
  logic [31:0]         predict_target;
  logic [GHR_BITS-1:0] predict_ghr;
  logic                ex_valid;
  logic [31:0]         pc_ex;
  logic                is_branch_ex;
  logic                is_jump_ex;
  logic                is_call_ex;
  logic                is_ret_ex;
  logic                branch_taken_ex;
  logic [31:0]         branch_target_ex;
  logic [GHR_BITS-1:0] ghr_ex;
  logic                mispredict_ex;

  modport master (
    output pc_if, if_valid, ex_valid, pc_ex, is_branch_ex, is_jump_ex,
           is_call_ex, is_ret_ex, branch_taken_ex, branch_target_ex,
           ghr_ex, mispredict_ex,
    input  predict_taken, predict_target, predict_ghr
  );

  modport slave (
    input  pc_if, if_valid, ex_valid, pc_ex, is_branch_ex, is_jump_ex,
           is_call_ex, is_ret_ex, branch_taken_ex, branch_target_ex,
           ghr_ex, mispredict_ex,
    output predict_taken, predict_target, predict_ghr
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Fetch predictor: direct-mapped BTB, gshare PHT and return address stack.
// Lookup is combinational in IF; EX trains the tables and repairs the GHR.
module branch_predictor_gshare #(
  parameter int BTB_ENTRIES = 64,
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_BITS    = 8,
  parameter int TAG_BITS    = 20,
  parameter int RAS_DEPTH   = 8
) (
  input logic                     clk,
  input logic                     rst,
  branch_predictor_gshare_if.slave bp
);
  localparam int BTB_IDX = $clog2(BTB_ENTRIES);
  localparam int PHT_IDX = $clog2(PHT_ENTRIES);
  localparam int RAS_IDX = $clog2(RAS_DEPTH);
  localparam int CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam int TAG_LO  = BTB_IDX + 2;
  localparam int TAG_HI  = BTB_IDX + 2 + TAG_BITS - 1;

  typedef enum logic [1:0] {
    BT_COND = 2'd0,
    BT_JUMP = 2'd1,
    BT_CALL = 2'd2,
    BT_RET  = 2'd3
  } btb_type_e;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_BITS-1:0]    btb_tag    [BTB_ENTRIES];
  logic [31:0]            btb_target [BTB_ENTRIES];
  btb_type_e              btb_type   [BTB_ENTRIES];
  logic [1:0]             pht        [PHT_ENTRIES];
  logic [GHR_BITS-1:0]    ghr;
  logic [31:0]            ras        [RAS_DEPTH];
  logic [RAS_IDX-1:0]     ras_ptr;
  logic [CNT_W-1:0]       ras_cnt;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic up);
    logic [1:0] res;
    res = ctr;
    if (up && ctr != 2'd3)
      res = ctr + 2'd1;
    else if (!up && ctr != 2'd0)
      res = ctr - 2'd1;
    return res;
  endfunction

  logic [BTB_IDX-1:0]  bidx_if;
  logic [TAG_BITS-1:0] tag_if;
  logic [PHT_IDX-1:0]  pidx_if;
  logic                hit_if;
  btb_type_e           type_if;
  logic [RAS_IDX-1:0]  ras_top_idx;
  logic [31:0]         pc_if_inc;

  assign bidx_if     = bp.pc_if[BTB_IDX+1:2];
  assign tag_if      = bp.pc_if[TAG_HI:TAG_LO];
  assign pidx_if     = bp.pc_if[PHT_IDX+1:2] ^ PHT_IDX'(ghr);
  assign hit_if      = btb_valid[bidx_if] && (btb_tag[bidx_if] == tag_if);
  assign type_if     = btb_type[bidx_if];
  assign ras_top_idx = ras_ptr - RAS_IDX'(1);
  assign pc_if_inc   = bp.pc_if + 32'd4;

  always_comb begin
    bp.predict_taken  = 1'b0;
    bp.predict_target = pc_if_inc;
    if (hit_if) begin
      bp.predict_target = btb_target[bidx_if];
      unique case (type_if)
        BT_COND: bp.predict_taken = pht[pidx_if][1];
        BT_JUMP,
        BT_CALL: bp.predict_taken = 1'b1;
        BT_RET: begin
          bp.predict_taken = 1'b1;
          if (ras_cnt != '0)
            bp.predict_target = ras[ras_top_idx];
        end
        default: bp.predict_taken = 1'b0;
      endcase
    end
  end

  assign bp.predict_ghr = ghr;

  // EX-side decode; mispredict is only meaningful alongside ex_valid
  logic               recover;
  logic               spec_en;
  logic [BTB_IDX-1:0] bidx_ex;
  logic [PHT_IDX-1:0] pidx_ex;
  logic               btb_we;
  btb_type_e          type_ex;

  assign recover = bp.ex_valid && bp.mispredict_ex;
  assign spec_en = bp.if_valid && !recover;
  assign bidx_ex = bp.pc_ex[BTB_IDX+1:2];
  assign pidx_ex = bp.pc_ex[PHT_IDX+1:2] ^ PHT_IDX'(bp.ghr_ex);
  assign btb_we  = bp.ex_valid && bp.branch_taken_ex &&
                   (bp.is_branch_ex || bp.is_jump_ex || bp.is_call_ex || bp.is_ret_ex);

  always_comb begin
    type_ex = BT_COND;
    if (bp.is_jump_ex)
      type_ex = BT_JUMP;
    else if (bp.is_call_ex)
      type_ex = BT_CALL;
    else if (bp.is_ret_ex)
      type_ex = BT_RET;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (recover) begin
      ghr <= bp.is_branch_ex ? {bp.ghr_ex[GHR_BITS-2:0], bp.branch_taken_ex} : bp.ghr_ex;
    end else if (spec_en && hit_if && type_if == BT_COND) begin
      ghr <= {ghr[GHR_BITS-2:0], bp.predict_taken};
    end
  end

  // RAS: ptr is the next free slot, a full push overwrites the oldest entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (spec_en && hit_if) begin
      if (type_if == BT_CALL) begin
        ras_ptr <= ras_ptr + RAS_IDX'(1);
        if (ras_cnt != CNT_W'(RAS_DEPTH))
          ras_cnt <= ras_cnt + CNT_W'(1);
      end else if (type_if == BT_RET && ras_cnt != '0) begin
        ras_ptr <= ras_ptr - RAS_IDX'(1);
        ras_cnt <= ras_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (spec_en && hit_if && type_if == BT_CALL)
      ras[ras_ptr] <= pc_if_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++)
        pht[i] <= 2'b01;
    end else if (bp.ex_valid && bp.is_branch_ex) begin
      pht[pidx_ex] <= sat_update(pht[pidx_ex], bp.branch_taken_ex);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      btb_valid <= '0;
    else if (btb_we)
      btb_valid[bidx_ex] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag[bidx_ex]    <= bp.pc_ex[TAG_HI:TAG_LO];
      btb_target[bidx_ex] <= bp.branch_target_ex;
      btb_type[bidx_ex]   <= type_ex;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bp.pc_if, bp.pc_ex};
endmodule
